stage_ex_md: RTL

- Parametrised execute stage for the br32 pipeline; successor to the single-cycle EX stage.
- Runs single-cycle ALU ops and iterative multi-cycle multiply/divide in one block.
- Stalls the decode stage while an iterative op is in flight; honours the exception flush.
- Sits between decode and memory stages; result register feeds MEM and the forwarding network.

---
 rtl/stage_ex_md_if.sv | 28 ++
 rtl/stage_ex_md.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_md_if.sv
// Decode <-> execute handshake for the br32 EX stage.
// The decode side is the master; the execute stage is the slave.
interface stage_ex_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_opc;
  logic [XLEN-1:0] in_op1;
  logic [XLEN-1:0] in_op2;
  logic [4:0]      in_rd;
  logic            in_w_rd;
  logic            out_valid;
  logic [XLEN-1:0] out_res;
  logic [4:0]      out_rd;
  logic            out_w_rd;
  logic            busy;

  modport master (
    output in_valid, in_opc, in_op1, in_op2, in_rd, in_w_rd,
    input  in_ready, out_valid, out_res, out_rd, out_w_rd, busy
  );

  modport slave (
    input  in_valid, in_opc, in_op1, in_op2, in_rd, in_w_rd,
    output in_ready, out_valid, out_res, out_rd, out_w_rd, busy
  );
endinterface

// File: rtl/stage_ex_md.sv
// br32 execute stage: single-cycle ALU plus iterative multiply/divide
// retiring UNROLL result bits per cycle.
module stage_ex_md #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         exn,
  stage_ex_md_if.slave bus
);
  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int SW    = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SAR   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_REM   = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_opc;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_res;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [4:0]      r_rd_pend;
  logic [4:0]      r_rd;
  logic            r_w_rd_pend;
  logic            r_out_valid;
  logic            r_out_w_rd;

  logic            w_accept;
  logic            w_is_iter;
  logic            w_is_mul;
  logic            w_is_sdiv;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN-1:0] w_res;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE) && !exn;
  assign w_is_iter = (bus.in_opc >= OP_MUL) && (bus.in_opc <= OP_REM);
  assign w_is_sdiv = (bus.in_opc == OP_DIV) || (bus.in_opc == OP_REM);
  assign w_is_mul  = (r_opc == OP_MUL) || (r_opc == OP_MULHU);
  assign w_shamt   = bus.in_op2[SW-1:0];
  assign w_abs1    = bus.in_op1[XLEN-1] ? -bus.in_op1 : bus.in_op1;
  assign w_abs2    = bus.in_op2[XLEN-1] ? -bus.in_op2 : bus.in_op2;

  // Single-cycle ALU result, captured at the accepting edge.
  always_comb begin
    w_alu = '0;
    case (bus.in_opc)
      OP_ADD:  w_alu = bus.in_op1 + bus.in_op2;
      OP_SUB:  w_alu = bus.in_op1 - bus.in_op2;
      OP_AND:  w_alu = bus.in_op1 & bus.in_op2;
      OP_OR:   w_alu = bus.in_op1 | bus.in_op2;
      OP_XOR:  w_alu = bus.in_op1 ^ bus.in_op2;
      OP_SHL:  w_alu = bus.in_op1 << w_shamt;
      OP_SHR:  w_alu = bus.in_op1 >> w_shamt;
      OP_SAR:  w_alu = $signed(bus.in_op1) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // UNROLL iterations of shift-add multiply or restoring divide.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  always_comb begin
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_sum   = '0;
    w_shift = '0;
    w_sub   = '0;
    w_ge    = 1'b0;
    for (int k = 0; k < UNROLL; k++) begin
      if (w_is_mul) begin
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
        w_hi  = w_sum[XLEN:1];
      end else begin
        w_shift = {w_hi, w_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        w_sub   = w_shift[XLEN-1:0] - r_opnd;
        w_hi    = w_ge ? w_sub : w_shift[XLEN-1:0];
        w_lo    = {w_lo[XLEN-2:0], w_ge};
      end
    end
  end

  // Final result selection and sign fix-up for the last iteration.
  always_comb begin
    w_res = '0;
    case (r_opc)
      OP_MUL:   w_res = w_lo;
      OP_MULHU: w_res = w_hi;
      OP_DIVU:  w_res = w_lo;
      OP_REMU:  w_res = w_hi;
      OP_DIV:   w_res = r_neg_q ? -w_lo : w_lo;
      OP_REM:   w_res = r_neg_r ? -w_hi : w_hi;
      default:  w_res = '0;
    endcase
  end

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_iter) w_state_nxt = S_BUSY;
        else                       w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (exn)                        w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(1))       w_state_nxt = S_DONE;
        else                            w_state_nxt = S_BUSY;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath and output registers; the valid pulse lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_opc       <= 4'd0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_res       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_rd_pend   <= 5'd0;
      r_rd        <= 5'd0;
      r_w_rd_pend <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_w_rd  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_w_rd  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_iter) begin
            r_opc       <= bus.in_opc;
            r_cnt       <= CW'(ITERS);
            r_hi        <= '0;
            r_rd_pend   <= bus.in_rd;
            r_w_rd_pend <= bus.in_w_rd;
            if (w_is_sdiv) begin
              r_lo    <= w_abs1;
              r_opnd  <= w_abs2;
              // Division by zero keeps the all-ones quotient unsigned.
              r_neg_q <= (bus.in_op1[XLEN-1] ^ bus.in_op2[XLEN-1]) && (|bus.in_op2);
              r_neg_r <= bus.in_op1[XLEN-1];
            end else begin
              r_lo    <= bus.in_op1;
              r_opnd  <= bus.in_op2;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end
          end else if (w_accept) begin
            r_res       <= w_alu;
            r_rd        <= bus.in_rd;
            r_out_valid <= 1'b1;
            r_out_w_rd  <= bus.in_w_rd;
          end
        end
        S_BUSY: begin
          if (!exn) begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_res       <= w_res;
              r_rd        <= r_rd_pend;
              r_out_valid <= 1'b1;
              r_out_w_rd  <= r_w_rd_pend;
            end
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_res   = r_res;
  assign bus.out_rd    = r_rd;
  assign bus.out_w_rd  = r_out_w_rd;
endmodule
